// File: rtl/dsp_mult_acc_pkg.sv
// Shared constants and helpers for the pipelined multiply / multiply-accumulate block.
package dsp_mult_acc_pkg;

  localparam logic MODE_MULT = 1'b0;
  localparam logic MODE_MAC  = 1'b1;

  // One guard bit lets unsigned operands sit inside a signed multiply.
  function automatic int ext_prod_width(input int a_width, input int b_width);
    return a_width + b_width + 1;
  endfunction

  function automatic logic acc_ovf(input logic is_signed, input logic carry,
                                   input logic msb_acc, input logic msb_prod,
                                   input logic msb_sum);
    if (is_signed)
      return (msb_acc == msb_prod) && (msb_sum != msb_acc);
    return carry;
  endfunction

endpackage

// File: rtl/dsp_mult_acc_operand_stage.sv
// Optional input register plus per-operand sign/zero extension to the multiplier width.
module dsp_mult_acc_operand_stage
  import dsp_mult_acc_pkg::*;
#(
  parameter int A_WIDTH = 20,
  parameter int B_WIDTH = 18,
  parameter int IN_REG  = 1,
  localparam int PW     = ext_prod_width(A_WIDTH, B_WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_valid,
  input  logic [A_WIDTH-1:0] i_a,
  input  logic [B_WIDTH-1:0] i_b,
  input  logic               i_signed_a,
  input  logic               i_signed_b,
  input  logic               i_mode,
  input  logic               i_acc_clr,
  output logic               o_valid,
  output logic [PW-1:0]      o_a_ext,
  output logic [PW-1:0]      o_b_ext,
  output logic               o_prod_signed,
  output logic               o_mode,
  output logic               o_acc_clr
);

  logic               w_valid;
  logic [A_WIDTH-1:0] w_a;
  logic [B_WIDTH-1:0] w_b;
  logic               w_signed_a;
  logic               w_signed_b;
  logic               w_mode;
  logic               w_acc_clr;

  generate
    if (IN_REG != 0) begin : g_in_reg
      logic               r_valid;
      logic [A_WIDTH-1:0] r_a;
      logic [B_WIDTH-1:0] r_b;
      logic               r_signed_a;
      logic               r_signed_b;
      logic               r_mode;
      logic               r_acc_clr;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid    <= 1'b0;
          r_a        <= '0;
          r_b        <= '0;
          r_signed_a <= 1'b0;
          r_signed_b <= 1'b0;
          r_mode     <= MODE_MULT;
          r_acc_clr  <= 1'b0;
        end else begin
          r_valid    <= i_valid;
          r_a        <= i_a;
          r_b        <= i_b;
          r_signed_a <= i_signed_a;
          r_signed_b <= i_signed_b;
          r_mode     <= i_mode;
          r_acc_clr  <= i_acc_clr;
        end
      end

      assign w_valid    = r_valid;
      assign w_a        = r_a;
      assign w_b        = r_b;
      assign w_signed_a = r_signed_a;
      assign w_signed_b = r_signed_b;
      assign w_mode     = r_mode;
      assign w_acc_clr  = r_acc_clr;
    end else begin : g_no_reg
      // Clock and reset have no job when the inputs feed straight through.
      logic w_unused_clk_rst;
      assign w_unused_clk_rst = clk ^ rst_n;

      assign w_valid    = i_valid;
      assign w_a        = i_a;
      assign w_b        = i_b;
      assign w_signed_a = i_signed_a;
      assign w_signed_b = i_signed_b;
      assign w_mode     = i_mode;
      assign w_acc_clr  = i_acc_clr;
    end
  endgenerate

  assign o_a_ext       = {{(PW-A_WIDTH){w_signed_a & w_a[A_WIDTH-1]}}, w_a};
  assign o_b_ext       = {{(PW-B_WIDTH){w_signed_b & w_b[B_WIDTH-1]}}, w_b};
  assign o_prod_signed = w_signed_a | w_signed_b;
  assign o_valid       = w_valid;
  assign o_mode        = w_mode;
  assign o_acc_clr     = w_acc_clr;

endmodule

// File: rtl/dsp_mult_acc_pipe.sv
// Pipelined multiply / multiply-accumulate with valid pipeline and sticky overflow.
module dsp_mult_acc_pipe
  import dsp_mult_acc_pkg::*;
#(
  parameter int A_WIDTH = 20,
  parameter int B_WIDTH = 18,
  parameter int Z_WIDTH = 38,
  parameter int IN_REG  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  input  logic               signed_a,
  input  logic               signed_b,
  input  logic               mode,
  input  logic               acc_clr,
  output logic [Z_WIDTH-1:0] z,
  output logic               out_valid,
  output logic               ovf
);

  localparam int PW = ext_prod_width(A_WIDTH, B_WIDTH);

  generate
    if (Z_WIDTH < A_WIDTH + B_WIDTH) begin : g_bad_width
      $error("dsp_mult_acc_pipe: Z_WIDTH must be at least A_WIDTH+B_WIDTH");
    end
  endgenerate

  logic                w_valid;
  logic [PW-1:0]       w_a_ext;
  logic [PW-1:0]       w_b_ext;
  logic                w_prod_signed;
  logic                w_mode;
  logic                w_acc_clr;
  logic signed [PW-1:0] w_prod_full;
  logic [Z_WIDTH-1:0]  w_prod;
  logic [Z_WIDTH:0]    w_sum;
  logic                w_ovf_now;

  logic [Z_WIDTH-1:0]  r_z;
  logic                r_out_valid;
  logic                r_ovf;

  dsp_mult_acc_operand_stage #(
    .A_WIDTH(A_WIDTH),
    .B_WIDTH(B_WIDTH),
    .IN_REG (IN_REG)
  ) u_operand_stage (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_valid      (in_valid),
    .i_a          (a),
    .i_b          (b),
    .i_signed_a   (signed_a),
    .i_signed_b   (signed_b),
    .i_mode       (mode),
    .i_acc_clr    (acc_clr),
    .o_valid      (w_valid),
    .o_a_ext      (w_a_ext),
    .o_b_ext      (w_b_ext),
    .o_prod_signed(w_prod_signed),
    .o_mode       (w_mode),
    .o_acc_clr    (w_acc_clr)
  );

  // The cast sign-extends when Z_WIDTH exceeds the product width, truncates otherwise.
  assign w_prod_full = $signed(w_a_ext) * $signed(w_b_ext);
  assign w_prod      = Z_WIDTH'(w_prod_full);
  assign w_sum       = {1'b0, r_z} + {1'b0, w_prod};
  assign w_ovf_now   = acc_ovf(w_prod_signed, w_sum[Z_WIDTH], r_z[Z_WIDTH-1],
                               w_prod[Z_WIDTH-1], w_sum[Z_WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_z         <= '0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_out_valid <= w_valid;
      if (w_valid) begin
        if (w_mode == MODE_MAC && !w_acc_clr) begin
          r_z   <= w_sum[Z_WIDTH-1:0];
          r_ovf <= r_ovf | w_ovf_now;
        end else begin
          r_z   <= w_prod;
          r_ovf <= 1'b0;
        end
      end
    end
  end

  assign z         = r_z;
  assign out_valid = r_out_valid;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_dsp_mult_acc_pipe.sv
// Directed bench driving an IN_REG=0 and an IN_REG=1 instance from the same stimulus.
module tb_dsp_mult_acc_pipe;

  typedef struct packed {
    logic        v;
    logic [19:0] a;
    logic [17:0] b;
    logic        sa;
    logic        sb;
    logic        md;
    logic        clr;
  } stim_t;

  // Observed/expected view of both instances: latency-1 (0) and latency-2 (1).
  typedef struct packed {
    logic        v0;
    logic [37:0] z0;
    logic        o0;
    logic        v1;
    logic [37:0] z1;
    logic        o1;
  } obs_t;

  localparam stim_t IDLE = '0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [19:0] a = '0;
  logic [17:0] b = '0;
  logic        signed_a = 1'b0;
  logic        signed_b = 1'b0;
  logic        mode = 1'b0;
  logic        acc_clr = 1'b0;
  logic [37:0] z0, z1;
  logic        v0, v1, o0, o1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dsp_mult_acc_pipe #(.A_WIDTH(20), .B_WIDTH(18), .Z_WIDTH(38), .IN_REG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .signed_a(signed_a), .signed_b(signed_b), .mode(mode), .acc_clr(acc_clr),
    .z(z0), .out_valid(v0), .ovf(o0)
  );

  dsp_mult_acc_pipe #(.A_WIDTH(20), .B_WIDTH(18), .Z_WIDTH(38), .IN_REG(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .signed_a(signed_a), .signed_b(signed_b), .mode(mode), .acc_clr(acc_clr),
    .z(z1), .out_valid(v1), .ovf(o1)
  );

  function automatic obs_t sample();
    obs_t o;
    o = '{v0, z0, o0, v1, z1, o1};
    return o;
  endfunction

  task automatic drive(input stim_t s);
    in_valid = s.v;
    a        = s.a;
    b        = s.b;
    signed_a = s.sa;
    signed_b = s.sb;
    mode     = s.md;
    acc_clr  = s.clr;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    drive(IDLE);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t got;
    rst_n = 1'b0;
    drive(IDLE);
    repeat (2) @(negedge clk);
    got = sample();
    vectors++;
    if (got !== obs_t'(0)) begin
      miscompares++;
      $display("FAIL reset: got %h want 0", got);
    end else $display("reset: outputs zero");
    rst_n = 1'b1;
  endtask

  task automatic test_mult_unsigned();
    stim_t s[3];
    obs_t  e[3];
    obs_t  got;
    s = '{'{1'b1, 20'hFFFFF, 18'h3FFFF, 1'b0, 1'b0, 1'b0, 1'b0}, IDLE, IDLE};
    e = '{'{1'b1, 38'h3FFFEC0001, 1'b0, 1'b0, 38'h0,          1'b0},
          '{1'b0, 38'h3FFFEC0001, 1'b0, 1'b1, 38'h3FFFEC0001, 1'b0},
          '{1'b0, 38'h3FFFEC0001, 1'b0, 1'b0, 38'h3FFFEC0001, 1'b0}};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive(s[i]);
      @(negedge clk);
      got = sample();
      vectors++;
      if (got !== e[i]) begin
        miscompares++;
        $display("FAIL mult_unsigned cyc%0d: got v0=%b z0=%h o0=%b v1=%b z1=%h o1=%b want v0=%b z0=%h o0=%b v1=%b z1=%h o1=%b",
                 i, got.v0, got.z0, got.o0, got.v1, got.z1, got.o1,
                 e[i].v0, e[i].z0, e[i].o0, e[i].v1, e[i].z1, e[i].o1);
      end else $display("mult_unsigned cyc%0d: z0=%h z1=%h ok", i, got.z0, got.z1);
    end
  endtask

  task automatic test_mult_signed();
    stim_t s[4];
    obs_t  e[4];
    obs_t  got;
    s = '{'{1'b1, 20'hFFFFF, 18'h3FFFF, 1'b1, 1'b1, 1'b0, 1'b0},
          '{1'b1, 20'hFFFFF, 18'h3FFFF, 1'b1, 1'b0, 1'b0, 1'b0}, IDLE, IDLE};
    e = '{'{1'b1, 38'h1,          1'b0, 1'b0, 38'h0,          1'b0},
          '{1'b1, 38'h3FFFFC0001, 1'b0, 1'b1, 38'h1,          1'b0},
          '{1'b0, 38'h3FFFFC0001, 1'b0, 1'b1, 38'h3FFFFC0001, 1'b0},
          '{1'b0, 38'h3FFFFC0001, 1'b0, 1'b0, 38'h3FFFFC0001, 1'b0}};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(s[i]);
      @(negedge clk);
      got = sample();
      vectors++;
      if (got !== e[i]) begin
        miscompares++;
        $display("FAIL mult_signed cyc%0d: got v0=%b z0=%h o0=%b v1=%b z1=%h o1=%b want v0=%b z0=%h o0=%b v1=%b z1=%h o1=%b",
                 i, got.v0, got.z0, got.o0, got.v1, got.z1, got.o1,
                 e[i].v0, e[i].z0, e[i].o0, e[i].v1, e[i].z1, e[i].o1);
      end else $display("mult_signed cyc%0d: z0=%h z1=%h ok", i, got.z0, got.z1);
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[4];
    obs_t  e[4];
    obs_t  got;
    s = '{'{1'b1, 20'd3, 18'd5, 1'b0, 1'b0, 1'b1, 1'b1},
          '{1'b1, 20'd2, 18'd7, 1'b0, 1'b0, 1'b1, 1'b0},
          '{1'b1, 20'd1, 18'd1, 1'b0, 1'b0, 1'b1, 1'b0}, IDLE};
    e = '{'{1'b1, 38'd15, 1'b0, 1'b0, 38'd0,  1'b0},
          '{1'b1, 38'd29, 1'b0, 1'b1, 38'd15, 1'b0},
          '{1'b1, 38'd30, 1'b0, 1'b1, 38'd29, 1'b0},
          '{1'b0, 38'd30, 1'b0, 1'b1, 38'd30, 1'b0}};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(s[i]);
      @(negedge clk);
      got = sample();
      vectors++;
      if (got !== e[i]) begin
        miscompares++;
        $display("FAIL back_to_back cyc%0d: got v0=%b z0=%h o0=%b v1=%b z1=%h o1=%b want v0=%b z0=%h o0=%b v1=%b z1=%h o1=%b",
                 i, got.v0, got.z0, got.o0, got.v1, got.z1, got.o1,
                 e[i].v0, e[i].z0, e[i].o0, e[i].v1, e[i].z1, e[i].o1);
      end else $display("back_to_back cyc%0d: z0=%0d z1=%0d ok", i, got.z0, got.z1);
    end
  endtask

  task automatic test_mac_gaps();
    stim_t s[8];
    obs_t  e[8];
    obs_t  got;
    s = '{'{1'b1, 20'd3, 18'd5, 1'b0, 1'b0, 1'b1, 1'b1}, IDLE, IDLE,
          '{1'b1, 20'd2, 18'd7, 1'b0, 1'b0, 1'b1, 1'b0}, IDLE, IDLE,
          '{1'b1, 20'd1, 18'd1, 1'b0, 1'b0, 1'b1, 1'b0}, IDLE};
    e = '{'{1'b1, 38'd15, 1'b0, 1'b0, 38'd0,  1'b0},
          '{1'b0, 38'd15, 1'b0, 1'b1, 38'd15, 1'b0},
          '{1'b0, 38'd15, 1'b0, 1'b0, 38'd15, 1'b0},
          '{1'b1, 38'd29, 1'b0, 1'b0, 38'd15, 1'b0},
          '{1'b0, 38'd29, 1'b0, 1'b1, 38'd29, 1'b0},
          '{1'b0, 38'd29, 1'b0, 1'b0, 38'd29, 1'b0},
          '{1'b1, 38'd30, 1'b0, 1'b0, 38'd29, 1'b0},
          '{1'b0, 38'd30, 1'b0, 1'b1, 38'd30, 1'b0}};
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      drive(s[i]);
      @(negedge clk);
      got = sample();
      vectors++;
      if (got !== e[i]) begin
        miscompares++;
        $display("FAIL mac_gaps cyc%0d: got v0=%b z0=%h o0=%b v1=%b z1=%h o1=%b want v0=%b z0=%h o0=%b v1=%b z1=%h o1=%b",
                 i, got.v0, got.z0, got.o0, got.v1, got.z1, got.o1,
                 e[i].v0, e[i].z0, e[i].o0, e[i].v1, e[i].z1, e[i].o1);
      end else $display("mac_gaps cyc%0d: z0=%0d z1=%0d ok", i, got.z0, got.z1);
    end
  endtask

  task automatic test_overflow();
    stim_t s[5];
    obs_t  e[5];
    obs_t  got;
    s = '{'{1'b1, 20'hFFFFF, 18'h3FFFF, 1'b0, 1'b0, 1'b1, 1'b1},
          '{1'b1, 20'hFFFFF, 18'h3FFFF, 1'b0, 1'b0, 1'b1, 1'b0}, IDLE,
          '{1'b1, 20'd1,     18'd1,     1'b0, 1'b0, 1'b1, 1'b1}, IDLE};
    e = '{'{1'b1, 38'h3FFFEC0001, 1'b0, 1'b0, 38'h0,          1'b0},
          '{1'b1, 38'h3FFFD80002, 1'b1, 1'b1, 38'h3FFFEC0001, 1'b0},
          '{1'b0, 38'h3FFFD80002, 1'b1, 1'b1, 38'h3FFFD80002, 1'b1},
          '{1'b1, 38'h1,          1'b0, 1'b0, 38'h3FFFD80002, 1'b1},
          '{1'b0, 38'h1,          1'b0, 1'b1, 38'h1,          1'b0}};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive(s[i]);
      @(negedge clk);
      got = sample();
      vectors++;
      if (got !== e[i]) begin
        miscompares++;
        $display("FAIL overflow cyc%0d: got v0=%b z0=%h o0=%b v1=%b z1=%h o1=%b want v0=%b z0=%h o0=%b v1=%b z1=%h o1=%b",
                 i, got.v0, got.z0, got.o0, got.v1, got.z1, got.o1,
                 e[i].v0, e[i].z0, e[i].o0, e[i].v1, e[i].z1, e[i].o1);
      end else $display("overflow cyc%0d: z0=%h o0=%b z1=%h o1=%b ok", i, got.z0, got.o0, got.z1, got.o1);
    end
  endtask

  task automatic test_async_reset();
    obs_t got;
    obs_t e[5];
    e = '{'{1'b1, 38'h3FFFD80003, 1'b1, 1'b0, 38'h3FFFD80002, 1'b1},
          obs_t'(0),
          obs_t'(0),
          '{1'b1, 38'd16, 1'b0, 1'b0, 38'd0,  1'b0},
          '{1'b0, 38'd16, 1'b0, 1'b1, 38'd16, 1'b0}};
    apply_reset();
    drive('{1'b1, 20'hFFFFF, 18'h3FFFF, 1'b0, 1'b0, 1'b1, 1'b1});
    @(negedge clk);
    drive('{1'b1, 20'hFFFFF, 18'h3FFFF, 1'b0, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    drive(IDLE);
    @(negedge clk);
    drive('{1'b1, 20'd1, 18'd1, 1'b0, 1'b0, 1'b1, 1'b0});
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin @(posedge clk); #2; end
        1: begin rst_n = 1'b0; #1; end
        2: begin @(negedge clk); drive(IDLE); rst_n = 1'b1; @(negedge clk); end
        3: begin drive('{1'b1, 20'd4, 18'd4, 1'b0, 1'b0, 1'b1, 1'b0}); @(negedge clk); end
        default: begin drive(IDLE); @(negedge clk); end
      endcase
      got = sample();
      vectors++;
      if (got !== e[i]) begin
        miscompares++;
        $display("FAIL async_reset step%0d: got v0=%b z0=%h o0=%b v1=%b z1=%h o1=%b want v0=%b z0=%h o0=%b v1=%b z1=%h o1=%b",
                 i, got.v0, got.z0, got.o0, got.v1, got.z1, got.o1,
                 e[i].v0, e[i].z0, e[i].o0, e[i].v1, e[i].z1, e[i].o1);
      end else $display("async_reset step%0d: z0=%h z1=%h ok", i, got.z0, got.z1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_mult_unsigned();
    test_mult_signed();
    test_back_to_back();
    test_mac_gaps();
    test_overflow();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
